// File: rtl/flow_table_lookup_if.sv
// Handshake bundle between the tuple hash stage, the flow table lookup and
// the per-flow queue selector.
interface flow_table_lookup_if #(
  parameter int FLOW_W = 16
);
  logic [95:0]       tuple_in;
  logic [31:0]       hash_in;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [FLOW_W-1:0] flow_id;
  logic              hit;
  logic              inserted;
  logic              collision;
  logic              table_full;

  modport master (
    output tuple_in, hash_in, in_valid, flush, out_ready,
    input  in_ready, out_valid, flow_id, hit, inserted, collision, table_full
  );

  modport slave (
    input  tuple_in, hash_in, in_valid, flush, out_ready,
    output in_ready, out_valid, flow_id, hit, inserted, collision, table_full
  );
endinterface

// File: rtl/flow_table_lookup.sv
// Direct-mapped flow table: resolves a 96-bit flow key plus its hash to a flow
// ID, allocating sequential IDs into empty slots. One lookup in flight at most.
module flow_table_lookup #(
  parameter int IDX_W  = 10,
  parameter int FLOW_W = 16
) (
  input logic              clk,
  input logic              rst,
  flow_table_lookup_if.slave bus
);

  localparam int KEY_W = 96;
  localparam int ENT_W = 1 + KEY_W + FLOW_W;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CMP  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  function automatic logic [ENT_W-1:0] pack_entry(input logic [KEY_W-1:0] key,
                                                  input logic [FLOW_W-1:0] id);
    return {1'b1, key, id};
  endfunction

  logic [2:0]        state;
  logic [IDX_W-1:0]  clr_idx;
  logic [FLOW_W-1:0] next_id;
  logic              flush_pend;
  logic              table_full;

  logic [KEY_W-1:0]  key_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [ENT_W-1:0]  rd_p1;

  logic              out_valid_q;
  logic              hit_q;
  logic              ins_q;
  logic              coll_q;
  logic [FLOW_W-1:0] id_q;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [ENT_W-1:0]  ram_wdata;

  logic              rd_vld;
  logic [KEY_W-1:0]  rd_key;
  logic [FLOW_W-1:0] rd_id;
  logic              key_match;
  logic              accept;
  logic              unused_hash;

  assign rd_vld    = rd_p1[ENT_W-1];
  assign rd_key    = rd_p1[FLOW_W +: KEY_W];
  assign rd_id     = rd_p1[FLOW_W-1:0];
  assign key_match = (rd_key == key_p0);

  assign bus.in_ready   = (state == ST_IDLE) && !flush_pend;
  assign accept         = bus.in_ready && bus.in_valid;
  assign bus.out_valid  = out_valid_q;
  assign bus.flow_id    = id_q;
  assign bus.hit        = hit_q;
  assign bus.inserted   = ins_q;
  assign bus.collision  = coll_q;
  assign bus.table_full = table_full;
  assign unused_hash    = ^bus.hash_in[31:IDX_W];

  // Single RAM port shared by the clear sweep, the lookup read and the insert.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = idx_p0;
    ram_wdata = '0;
    case (state)
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = clr_idx;
      end
      ST_IDLE: begin
        if (accept) begin
          ram_re   = 1'b1;
          ram_addr = bus.hash_in[IDX_W-1:0];
        end
      end
      ST_CMP: begin
        if (!rd_vld && !table_full) begin
          ram_we    = 1'b1;
          ram_wdata = pack_entry(key_p0, next_id);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (ram_re) rd_p1 <= mem[ram_addr];
  end

  // Stage p0: key and index latched on accept; never reset, only control is.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_p0 <= bus.tuple_in;
      idx_p0 <= bus.hash_in[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_INIT;
      clr_idx     <= '0;
      next_id     <= '0;
      flush_pend  <= 1'b0;
      table_full  <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      ins_q       <= 1'b0;
      coll_q      <= 1'b0;
      id_q        <= '0;
    end else begin
      if (bus.flush && state != ST_INIT) flush_pend <= 1'b1;
      case (state)
        ST_INIT: begin
          if (bus.flush) begin
            clr_idx <= '0;
          end else if (clr_idx == '1) begin
            clr_idx <= '0;
            state   <= ST_IDLE;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (flush_pend) begin
            flush_pend <= 1'b0;
            next_id    <= '0;
            table_full <= 1'b0;
            clr_idx    <= '0;
            state      <= ST_INIT;
          end else if (bus.in_valid) begin
            state <= ST_RD;
          end
        end
        ST_RD: state <= ST_CMP;
        // Stage p1: read data is compared and the result registered.
        ST_CMP: begin
          out_valid_q <= 1'b1;
          state       <= ST_OUT;
          hit_q       <= 1'b0;
          ins_q       <= 1'b0;
          coll_q      <= 1'b0;
          id_q        <= '0;
          if (rd_vld && key_match) begin
            hit_q <= 1'b1;
            id_q  <= rd_id;
          end else if (rd_vld) begin
            coll_q <= 1'b1;
          end else if (!table_full) begin
            ins_q <= 1'b1;
            id_q  <= next_id;
            if (next_id == '1) table_full <= 1'b1;
            else next_id <= next_id + FLOW_W'(1);
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_table_lookup.sv
// Directed bench for flow_table_lookup with a 16-entry table and 2-bit IDs.
module tb_flow_table_lookup;

  localparam int IDX_W  = 4;
  localparam int FLOW_W = 2;

  localparam logic [95:0] K1 = 96'h0A000001_1234_0A000002_0050;
  localparam logic [95:0] K2 = 96'hC0A80001_4321_C0A80002_01BB;
  localparam logic [95:0] K3 = 96'h0A000003_1111_0A000004_0016;
  localparam logic [95:0] K4 = 96'h0A000005_2222_0A000006_0035;
  localparam logic [95:0] K5 = 96'h0A000007_3333_0A000008_0019;
  localparam logic [95:0] K6 = 96'h0A000009_4444_0A00000A_0017;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  flow_table_lookup_if #(.FLOW_W(FLOW_W)) bus ();

  flow_table_lookup #(.IDX_W(IDX_W), .FLOW_W(FLOW_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start(input logic [95:0] key, input logic [31:0] hash, input logic rdy);
    int n;
    n = 0;
    @(negedge clk);
    bus.tuple_in  = key;
    bus.hash_in   = hash;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.tuple_in = '0;
    bus.hash_in  = '0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic lookup(input logic [95:0] key, input logic [31:0] hash, input logic rdy,
                        output int lat);
    start(key, hash, rdy);
    wait_result(lat);
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (bus.in_ready) break;
      cnt++;
    end
  endtask

  task automatic test_reset;
    int cnt;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.tuple_in = K1;
    bus.hash_in = 32'h5;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_handshake: in_ready/out_valid=%b required 00", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.flow_id, bus.hit, bus.inserted, bus.collision, bus.table_full} !== 6'b0) begin
      errors++;
      $display("FAIL reset_result: id/h/i/c/full=%b required 000000",
               {bus.flow_id, bus.hit, bus.inserted, bus.collision, bus.table_full});
    end
    rst_n = 1'b1;
    wait_init(cnt);
    bus.in_valid = 1'b0;
    checks++;
    if (cnt !== 15) begin
      errors++;
      $display("FAIL reset_init_len: in_ready low for %0d negedges after release, required 15", cnt);
    end
  endtask

  task automatic test_insert_hit;
    int lat;
    lookup(K1, 32'h5, 1'b1, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL first_latency: %0d required 3", lat);
    end
    checks++;
    if ({bus.hit, bus.inserted, bus.collision, bus.flow_id} !== {3'b010, 2'd0}) begin
      errors++;
      $display("FAIL first_insert: h/i/c/id=%b required 01000", {bus.hit, bus.inserted, bus.collision, bus.flow_id});
    end
    lookup(K1, 32'h5, 1'b1, lat);
    checks++;
    if ({bus.hit, bus.inserted, bus.collision, bus.flow_id} !== {3'b100, 2'd0}) begin
      errors++;
      $display("FAIL repeat_hit: h/i/c/id=%b required 10000", {bus.hit, bus.inserted, bus.collision, bus.flow_id});
    end
    lookup(K2, 32'h15, 1'b1, lat);
    checks++;
    if ({bus.hit, bus.inserted, bus.collision, bus.flow_id} !== {3'b001, 2'd0}) begin
      errors++;
      $display("FAIL collision: h/i/c/id=%b required 00100", {bus.hit, bus.inserted, bus.collision, bus.flow_id});
    end
  endtask

  task automatic test_full;
    int lat;
    lookup(K3, 32'h1, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.flow_id, bus.table_full} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL insert_id1: i/id/full=%b required 1010", {bus.inserted, bus.flow_id, bus.table_full});
    end
    lookup(K4, 32'h2, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.flow_id, bus.table_full} !== {1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL insert_id2: i/id/full=%b required 1100", {bus.inserted, bus.flow_id, bus.table_full});
    end
    lookup(K5, 32'h3, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.flow_id, bus.table_full} !== {1'b1, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL insert_id3_full: i/id/full=%b required 1111", {bus.inserted, bus.flow_id, bus.table_full});
    end
    lookup(K6, 32'h4, 1'b1, lat);
    checks++;
    if ({bus.hit, bus.inserted, bus.collision, bus.flow_id, bus.table_full} !== 6'b000001) begin
      errors++;
      $display("FAIL full_no_alloc: h/i/c/id/full=%b required 000001",
               {bus.hit, bus.inserted, bus.collision, bus.flow_id, bus.table_full});
    end
    lookup(K4, 32'h2, 1'b1, lat);
    checks++;
    if ({bus.hit, bus.inserted, bus.collision, bus.flow_id} !== {3'b100, 2'd2}) begin
      errors++;
      $display("FAIL hit_when_full: h/i/c/id=%b required 10010", {bus.hit, bus.inserted, bus.collision, bus.flow_id});
    end
  endtask

  task automatic test_backpressure;
    int lat;
    lookup(K1, 32'h5, 1'b0, lat);
    checks++;
    if ({bus.hit, bus.flow_id} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL bp_result: hit/id=%b required 100", {bus.hit, bus.flow_id});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.hit, bus.inserted, bus.collision, bus.flow_id, bus.in_ready} !== 7'b1100000) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ov/h/i/c/id/in_ready=%b required 1100000", i,
                 {bus.out_valid, bus.hit, bus.inserted, bus.collision, bus.flow_id, bus.in_ready});
      end
    end
    bus.out_ready = 1'b1;
    bus.tuple_in  = K3;
    bus.hash_in   = 32'h1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if ({lat[3:0], bus.hit, bus.flow_id} !== {4'd3, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL bp_next_lookup: lat=%0d hit=%b id=%0d required lat 3 hit 1 id 1", lat, bus.hit, bus.flow_id);
    end
  endtask

  task automatic test_flush;
    int lat;
    int cnt;
    start(K4, 32'h2, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    wait_result(lat);
    checks++;
    if ({bus.out_valid, bus.hit, bus.flow_id} !== {2'b11, 2'd2}) begin
      errors++;
      $display("FAIL flush_inflight: ov/hit/id=%b required 1110", {bus.out_valid, bus.hit, bus.flow_id});
    end
    wait_init(cnt);
    checks++;
    if (cnt !== 17) begin
      errors++;
      $display("FAIL flush_init_len: in_ready low for %0d negedges, required 17", cnt);
    end
    checks++;
    if (bus.table_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_clear: table_full=%b required 0", bus.table_full);
    end
    lookup(K1, 32'h5, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.flow_id, bus.table_full} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL flush_reinsert: i/id/full=%b required 1000", {bus.inserted, bus.flow_id, bus.table_full});
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int cnt;
    start(K3, 32'h1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_cmp: out_valid/in_ready=%b required 00", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cnt);
    checks++;
    if (cnt !== 15) begin
      errors++;
      $display("FAIL rst_cmp_init: in_ready low for %0d negedges, required 15", cnt);
    end
    lookup(K1, 32'h5, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.hit, bus.flow_id} !== {2'b10, 2'd0}) begin
      errors++;
      $display("FAIL rst_cmp_reinsert: i/h/id=%b required 1000", {bus.inserted, bus.hit, bus.flow_id});
    end
    lookup(K1, 32'h5, 1'b0, lat);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.hit, bus.inserted, bus.flow_id} !== 5'b0) begin
      errors++;
      $display("FAIL rst_out_async: ov/h/i/id=%b required 00000", {bus.out_valid, bus.hit, bus.inserted, bus.flow_id});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cnt);
    lookup(K1, 32'h5, 1'b1, lat);
    checks++;
    if ({bus.inserted, bus.hit, bus.flow_id} !== {2'b10, 2'd0}) begin
      errors++;
      $display("FAIL rst_out_reinsert: i/h/id=%b required 1000", {bus.inserted, bus.hit, bus.flow_id});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.tuple_in  = '0;
    bus.hash_in   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_insert_hit();
    test_full();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
